inc_scheduler: RTL and testbench

//  Shares the per-digit increment path between the DIGITS button requesters.

---
 rtl/inc_scheduler.sv | 177 +++++++++++++++++
 tb/tb_inc_scheduler.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/inc_scheduler.sv
// -----------------------------------------------------------------------------
// inc_scheduler
// Shares the per-digit increment path between DIGITS button requesters.
// Synchronized button levels are turned into press events plus hold-to-
// autorepeat events, paced by the clock scaler's tick. Events are latched
// one bit per requester and then granted one at a time by a round-robin
// arbiter as single-cycle, one-hot increment pulses.
//
// Ports
//   clk     in   1       system clock
//   reset   in   1       synchronous, active-high reset
//   req     in   DIGITS  synchronized button levels, bit j = digit j
//   tick    in   1       single-cycle timebase pulse
//   freeze  in   1       suppresses grants; events keep accumulating
//   grant   out  DIGITS  one-hot increment pulse, one cycle wide
//   busy    out  1       high while any event is pending
// -----------------------------------------------------------------------------
module inc_scheduler #(
    parameter int unsigned DIGITS       = 4,
    parameter int unsigned HOLD_TICKS   = 8,
    parameter int unsigned REPEAT_TICKS = 2,
    parameter int unsigned CNT_W        = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DIGITS-1:0] req,
    input  logic              tick,
    input  logic              freeze,
    output logic [DIGITS-1:0] grant,
    output logic              busy
);

    localparam int unsigned PTR_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    // Elaboration-time parameter sanity
    if (HOLD_TICKS < 1 || REPEAT_TICKS < 1) begin : g_bad_ticks
        $error("inc_scheduler: HOLD_TICKS and REPEAT_TICKS must be >= 1");
    end
    if (HOLD_TICKS > (2**CNT_W) - 1 || REPEAT_TICKS > (2**CNT_W) - 1) begin : g_bad_cnt_w
        $error("inc_scheduler: CNT_W too narrow for the tick thresholds");
    end

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_HOLD   = 2'd1,
        ST_REPEAT = 2'd2
    } state_t;

    // Registered state
    logic [DIGITS-1:0] r_req_d;
    logic [DIGITS-1:0] r_pending;
    logic [DIGITS-1:0] r_grant;
    logic              r_busy;
    logic [PTR_W-1:0]  r_rr_ptr;
    state_t            r_state [DIGITS];
    logic [CNT_W-1:0]  r_cnt   [DIGITS];

    // Combinational helpers
    logic [DIGITS-1:0] w_rise;
    logic [DIGITS-1:0] w_hold_hit;
    logic [DIGITS-1:0] w_rep_hit;
    logic [DIGITS-1:0] w_evt;
    logic [CNT_W-1:0]  w_cnt_inc [DIGITS];
    logic [PTR_W:0]    w_idx_sum;
    logic              w_found;
    logic [PTR_W-1:0]  w_sel;
    logic [PTR_W-1:0]  w_ptr_nxt;
    logic [DIGITS-1:0] w_clr;
    logic [DIGITS-1:0] w_pending_nxt;

    assign grant = r_grant;
    assign busy  = r_busy;

    // Event generation: press edges plus hold/repeat threshold hits on a tick.
    // A release in the same cycle as a tick wins, so no event on release.
    always_comb begin
        w_rise     = req & ~r_req_d;
        w_hold_hit = '0;
        w_rep_hit  = '0;
        w_evt      = '0;
        for (int j = 0; j < DIGITS; j++) begin
            w_cnt_inc[j]  = r_cnt[j] + CNT_W'(1);
            w_hold_hit[j] = (r_state[j] == ST_HOLD) && req[j] && tick &&
                            (w_cnt_inc[j] == CNT_W'(HOLD_TICKS));
            w_rep_hit[j]  = (r_state[j] == ST_REPEAT) && req[j] && tick &&
                            (w_cnt_inc[j] == CNT_W'(REPEAT_TICKS));
            w_evt[j]      = w_rise[j] | w_hold_hit[j] | w_rep_hit[j];
        end
    end

    // Round-robin pick: first pending index at or after r_rr_ptr, circularly
    always_comb begin
        w_found   = 1'b0;
        w_sel     = '0;
        w_idx_sum = '0;
        for (int i = 0; i < DIGITS; i++) begin
            w_idx_sum = {1'b0, r_rr_ptr} + (PTR_W+1)'(i);
            if (w_idx_sum >= (PTR_W+1)'(DIGITS)) begin
                w_idx_sum = w_idx_sum - (PTR_W+1)'(DIGITS);
            end
            if (!w_found && r_pending[w_idx_sum[PTR_W-1:0]]) begin
                w_found = 1'b1;
                w_sel   = w_idx_sum[PTR_W-1:0];
            end
        end

        w_clr     = '0;
        w_ptr_nxt = r_rr_ptr;
        if (!freeze && w_found) begin
            w_clr[w_sel] = 1'b1;
            w_ptr_nxt    = (w_sel == PTR_W'(DIGITS - 1)) ? '0 : w_sel + PTR_W'(1);
        end

        // A new event on the bit being granted survives the clear
        w_pending_nxt = (r_pending & ~w_clr) | w_evt;
    end

    // State register: edge detect, arbitration results and per-requester FSMs
    always_ff @(posedge clk) begin
        if (reset) begin
            r_req_d   <= '0;
            r_pending <= '0;
            r_grant   <= '0;
            r_busy    <= 1'b0;
            r_rr_ptr  <= '0;
            for (int j = 0; j < DIGITS; j++) begin
                r_state[j] <= ST_IDLE;
                r_cnt[j]   <= '0;
            end
        end else begin
            r_req_d   <= req;
            r_pending <= w_pending_nxt;
            r_grant   <= w_clr;
            r_busy    <= |w_pending_nxt;
            r_rr_ptr  <= w_ptr_nxt;

            for (int j = 0; j < DIGITS; j++) begin
                case (r_state[j])
                    ST_IDLE: begin
                        if (w_rise[j]) begin
                            r_state[j] <= ST_HOLD;
                            r_cnt[j]   <= '0;
                        end
                    end
                    ST_HOLD: begin
                        if (!req[j]) begin
                            r_state[j] <= ST_IDLE;
                        end else if (tick) begin
                            if (w_hold_hit[j]) begin
                                r_state[j] <= ST_REPEAT;
                                r_cnt[j]   <= '0;
                            end else begin
                                r_cnt[j]   <= w_cnt_inc[j];
                            end
                        end
                    end
                    ST_REPEAT: begin
                        if (!req[j]) begin
                            r_state[j] <= ST_IDLE;
                        end else if (tick) begin
                            if (w_rep_hit[j]) begin
                                r_cnt[j] <= '0;
                            end else begin
                                r_cnt[j] <= w_cnt_inc[j];
                            end
                        end
                    end
                    default: begin
                        r_state[j] <= ST_IDLE;
                        r_cnt[j]   <= '0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_inc_scheduler.sv
// -----------------------------------------------------------------------------
// tb_inc_scheduler
// Directed stimulus for inc_scheduler. A behavioural model (tick count since
// press, a pending set and a circular pointer) predicts grant/busy every
// cycle; hand-computed literal checks pin key scenarios.
// -----------------------------------------------------------------------------
module tb_inc_scheduler;

    localparam int DIGITS = 4;
    localparam int HOLD   = 8;
    localparam int REP    = 2;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] req;
    logic       tick;
    logic       freeze;
    logic [3:0] grant;
    logic       busy;

    always #5 clk = ~clk;

    inc_scheduler #(
        .DIGITS       (4),
        .HOLD_TICKS   (8),
        .REPEAT_TICKS (2),
        .CNT_W        (4)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .req    (req),
        .tick   (tick),
        .freeze (freeze),
        .grant  (grant),
        .busy   (busy)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [3:0] m_pend, m_prev, m_grant, m_ev, m_g;
    logic       m_busy;
    bit         m_valid = 1'b0;
    bit         m_active [DIGITS];
    int         m_ticks  [DIGITS];
    int         m_ptr, m_sel, m_idx;
    int         g_cnt    [DIGITS];

    initial for (int j = 0; j < DIGITS; j++) g_cnt[j] = 0;

    always @(posedge clk) begin
        if (reset) begin
            m_pend  = '0;
            m_prev  = '0;
            m_grant = '0;
            m_busy  = 1'b0;
            m_ptr   = 0;
            m_valid = 1'b1;
            for (int j = 0; j < DIGITS; j++) begin
                m_active[j] = 1'b0;
                m_ticks[j]  = 0;
            end
        end else begin
            m_ev = '0;
            m_g  = '0;
            for (int j = 0; j < DIGITS; j++) begin
                if (req[j] && !m_prev[j]) begin
                    m_ev[j]     = 1'b1;
                    m_active[j] = 1'b1;
                    m_ticks[j]  = 0;
                end else if (!req[j]) begin
                    m_active[j] = 1'b0;
                end else if (m_active[j] && tick) begin
                    m_ticks[j]++;
                    if (m_ticks[j] == HOLD ||
                        (m_ticks[j] > HOLD && ((m_ticks[j] - HOLD) % REP) == 0))
                        m_ev[j] = 1'b1;
                end
            end
            m_prev = req;

            m_sel = -1;
            for (int k = 0; k < DIGITS; k++) begin
                m_idx = (m_ptr + k) % DIGITS;
                if (m_sel < 0 && m_pend[m_idx]) m_sel = m_idx;
            end
            if (!freeze && m_sel >= 0) begin
                m_g[m_sel]    = 1'b1;
                m_pend[m_sel] = 1'b0;
                m_ptr         = (m_sel + 1) % DIGITS;
            end
            m_pend  = m_pend | m_ev;
            m_grant = m_g;
            m_busy  = |m_pend;
        end
    end

    // Cycle-by-cycle comparison against the model
    always @(negedge clk) begin
        if (m_valid) begin
            check("grant_vs_model", 32'(grant), 32'(m_grant));
            check("busy_vs_model",  32'(busy),  32'(m_busy));
            for (int j = 0; j < DIGITS; j++) if (grant[j] === 1'b1) g_cnt[j]++;
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        reset  = 1'b1;
        req    = '0;
        tick   = 1'b0;
        freeze = 1'b0;
        cyc(2);
        reset  = 1'b0;
    endtask

    // n tick periods of 10 cycles, tick on the last cycle of each
    task automatic tick_periods(input int n);
        repeat (n) begin
            tick = 1'b0;
            cyc(9);
            tick = 1'b1;
            cyc(1);
            tick = 1'b0;
        end
    endtask

    int base;

    initial begin
        do_reset();
        check("reset_grant", 32'(grant), 32'h0);
        check("reset_busy",  32'(busy),  32'h0);

        // 1: single tap on digit 2
        req = 4'b0100; cyc(1); req = '0;
        check("t1_busy_set",   32'(busy),  32'h1);
        check("t1_no_grant_e0", 32'(grant), 32'h0);
        cyc(1);
        check("t1_grant",      32'(grant), 32'h4);
        check("t1_busy_clr",   32'(busy),  32'h0);
        cyc(1);
        check("t1_grant_1cyc", 32'(grant), 32'h0);

        // 2: all four rise together, round-robin from 0
        do_reset();
        req = 4'b1111; cyc(1); req = '0;
        check("t2_no_grant_e0", 32'(grant), 32'h0);
        for (int k = 0; k < 4; k++) begin
            cyc(1);
            check("t2_grant_seq", 32'(grant), 32'(1 << k));
        end
        check("t2_busy_end", 32'(busy), 32'h0);
        cyc(1);
        check("t2_idle", 32'(grant), 32'h0);
        // pointer back at 0: digit 0 wins over digit 3
        req = 4'b1001; cyc(1); req = '0;
        cyc(1); check("t2_ptr0_first",  32'(grant), 32'h1);
        cyc(1); check("t2_ptr0_second", 32'(grant), 32'h8);
        cyc(2);

        // 3: fairness with pointer at 2
        do_reset();
        req = 4'b0010; cyc(1); req = '0;
        cyc(1); check("t3_grant1", 32'(grant), 32'h2);
        cyc(1);
        req = 4'b1001; cyc(1); req = '0;
        cyc(1); check("t3_first",  32'(grant), 32'h8);
        cyc(1); check("t3_second", 32'(grant), 32'h1);
        cyc(1); check("t3_idle",   32'(grant), 32'h0);

        // 4: autorepeat on digit 0, 14 ticks held -> press + 8th + 10th,12th,14th
        do_reset();
        base = g_cnt[0];
        req = 4'b0001;
        tick_periods(14);
        cyc(4);
        check("t4_hold_grants", 32'(g_cnt[0] - base), 32'd5);
        req = '0;
        base = g_cnt[0];
        tick_periods(3);
        cyc(2);
        check("t4_after_release", 32'(g_cnt[0] - base), 32'd0);
        check("t4_busy_idle", 32'(busy), 32'h0);

        // 5: freeze holds grants, resume in round-robin order
        do_reset();
        freeze = 1'b1;
        req = 4'b1010; cyc(1); req = '0;
        cyc(3);
        check("t5_frozen_grant", 32'(grant), 32'h0);
        check("t5_frozen_busy",  32'(busy),  32'h1);
        freeze = 1'b0;
        cyc(1);
        check("t5_first",      32'(grant), 32'h2);
        check("t5_busy_mid",   32'(busy),  32'h1);
        cyc(1);
        check("t5_second",     32'(grant), 32'h8);
        check("t5_busy_fall",  32'(busy),  32'h0);
        cyc(1);
        check("t5_idle",       32'(grant), 32'h0);

        // 7: merging while frozen, and set winning over a same-cycle clear
        do_reset();
        freeze = 1'b1;
        req = 4'b0001; cyc(1); req = '0; cyc(1);
        req = 4'b0001; cyc(1); req = '0; cyc(1);
        freeze = 1'b0;
        req = 4'b0001; cyc(1); req = '0;
        check("t7_grant_a", 32'(grant), 32'h1);
        check("t7_busy_kept", 32'(busy), 32'h1);
        cyc(1);
        check("t7_grant_b", 32'(grant), 32'h1);
        check("t7_busy_clr", 32'(busy), 32'h0);
        cyc(1);
        check("t7_merged_idle", 32'(grant), 32'h0);

        // 6: reset while digit 1 repeats, keep holding, then re-press
        do_reset();
        req = 4'b0010;
        tick_periods(9);
        cyc(3);
        reset = 1'b1;
        cyc(1);
        check("t6_reset_grant", 32'(grant), 32'h0);
        check("t6_reset_busy",  32'(busy),  32'h0);
        reset = 1'b0;
        tick_periods(20);
        cyc(4);
        req = '0;
        cyc(4);
        base = g_cnt[1];
        req = 4'b0010; cyc(1); req = '0;
        cyc(4);
        check("t6_repress_one", 32'(g_cnt[1] - base), 32'd1);

        cyc(2);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
